// File: rtl/narrow_saturate_32to16_pkg.sv
// Shared definitions for the 32-to-16 narrowing/saturation block and its users.
package narrow_saturate_32to16_pkg;

    localparam int IN_W_DEF  = 32;
    localparam int OUT_W_DEF = 16;
    localparam int CNT_W_DEF = 16;

    // Clamp values used when an out-of-range word is saturated.
    localparam logic [OUT_W_DEF-1:0] SAT_POS = 16'h7FFF;
    localparam logic [OUT_W_DEF-1:0] SAT_NEG = 16'h8000;

    // Narrowed word plus its out-of-range flag, as carried down the pipeline.
    typedef struct packed {
        logic [OUT_W_DEF-1:0] data;
        logic                 ovf;
    } narrow_payload_t;

endpackage

// File: rtl/narrow_saturate_32to16_if.sv
// Valid/ready stream bundle: wide signed words in, narrowed words out.
interface narrow_saturate_32to16_if
    import narrow_saturate_32to16_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             in_sat_en;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_ovf;

    // Producer of input words and consumer of narrowed words.
    modport master (
        output in_valid, in_data, in_sat_en, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    // The narrowing block itself.
    modport slave (
        input  in_valid, in_data, in_sat_en, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/narrow_saturate_32to16_range_check.sv
// Combinational range check: does a signed wide word survive narrowing, and
// what should the narrow result be (truncated or clamped).
module narrow_saturate_32to16_range_check
    import narrow_saturate_32to16_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic [IN_W-1:0]  in_data,
    input  logic             sat_en,
    output logic [OUT_W-1:0] result,
    output logic             ovf
);

    // Bits from the narrow sign bit up to the wide sign bit must all agree.
    localparam int HI_N = IN_W - OUT_W + 1;

    logic [HI_N-1:0] bit_match;
    logic            fits;

    genvar gi;
    generate
        for (gi = 0; gi < HI_N; gi++) begin : g_match
            assign bit_match[gi] = (in_data[OUT_W-1+gi] == in_data[IN_W-1]);
        end
    endgenerate

    assign fits = &bit_match;

    // Truncate by default; clamp toward the sign only when asked and needed.
    always_comb begin
        ovf    = !fits;
        result = in_data[OUT_W-1:0];
        if (!fits && sat_en) begin
            result = in_data[IN_W-1] ? SAT_NEG : SAT_POS;
        end
    end

endmodule

// File: rtl/narrow_saturate_32to16.sv
// Two-stage valid/ready pipeline narrowing 32-bit signed words to 16 bits,
// with a sticky overflow flag and a saturating overflow event counter.
module narrow_saturate_32to16
    import narrow_saturate_32to16_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    narrow_saturate_32to16_if.slave   bus,
    input  logic                      clr,
    output logic                      ovf_sticky,
    output logic [CNT_W-1:0]          ovf_count
);

    logic            s1_valid_reg;
    narrow_payload_t s1_payload_reg;
    logic            s2_valid_reg;
    narrow_payload_t s2_payload_reg;
    logic            ovf_sticky_reg;
    logic [CNT_W-1:0] ovf_count_reg;

    narrow_payload_t cand;
    logic            s2_advance;
    logic            s1_advance;
    logic            in_ready_int;
    logic            accept;
    logic            deliver;
    logic            ovf_event;

    // Range check on the incoming word; its verdict (fits = !ovf) and the
    // narrowed candidate are captured in stage 1 at acceptance, so the mode
    // bit is frozen per word and later sat_en changes cannot leak in.
    narrow_saturate_32to16_range_check #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_range_check (
        .in_data (bus.in_data),
        .sat_en  (bus.in_sat_en),
        .result  (cand.data),
        .ovf     (cand.ovf)
    );

    // Handshake: stage 2 moves when empty or being drained, stage 1 follows it.
    // rst_n gates in_ready so nothing is offered as accepted while in reset.
    assign s2_advance   = !s2_valid_reg || bus.out_ready;
    assign s1_advance   = s2_advance;
    assign in_ready_int = rst_n && (!s1_valid_reg || s1_advance);
    assign accept       = bus.in_valid && in_ready_int;
    assign deliver      = s2_valid_reg && bus.out_ready;
    assign ovf_event    = deliver && s2_payload_reg.ovf;

    // Pipeline registers; payloads only load when a real word moves in so
    // out_data stays put while the output is stalled or idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg   <= 1'b0;
            s1_payload_reg <= '0;
            s2_valid_reg   <= 1'b0;
            s2_payload_reg <= '0;
        end else begin
            if (s1_advance) begin
                s2_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    s2_payload_reg <= s1_payload_reg;
                end
            end
            if (in_ready_int) begin
                s1_valid_reg <= bus.in_valid;
                if (accept) begin
                    s1_payload_reg <= cand;
                end
            end
        end
    end

    // Overflow bookkeeping on delivery; a clear in the same cycle as an
    // overflow delivery leaves exactly that one event recorded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky_reg <= 1'b0;
            ovf_count_reg  <= '0;
        end else if (clr) begin
            ovf_sticky_reg <= ovf_event;
            ovf_count_reg  <= ovf_event ? CNT_W'(1) : '0;
        end else if (ovf_event) begin
            ovf_sticky_reg <= 1'b1;
            if (ovf_count_reg != '1) begin
                ovf_count_reg <= ovf_count_reg + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = s2_valid_reg;
    assign bus.out_data  = s2_payload_reg.data;
    assign bus.out_ovf   = s2_payload_reg.ovf;
    assign ovf_sticky    = ovf_sticky_reg;
    assign ovf_count     = ovf_count_reg;

endmodule
